data_memory_bytelane: RTL
=========================

# data_memory_bytelane

Byte-addressed, parametrised data memory for the MEM stage of the pipelined core. It supports byte, half, word and (at 64-bit width) double accesses with correct lane placement and sign/zero extension. Reads are fully pipelined with a configurable latency and a valid strobe; misaligned accesses are detected and flagged instead of corrupting memory. It sits between the EX/MEM pipeline register and the MEM/WB register, and its control inputs are decoded directly from the load/store funct3.

## Interface
- MEM_DEPTH, 1024: number of DATA_LENGTH-wide words; power of 2.
- DATA_LENGTH, 32: data word width; 32 or 64.
- ADDR_LENGTH, 32: byte address width.
- READ_LATENCY, 1: read pipeline depth; 1 or 2.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_Addr  in  ADDR_LENGTH  byte address.
- i_We  in  1  store request.
- i_Re  in  1  load request.
- i_size  in  2  00 byte, 01 half, 10 32-bit word, 11 full DATA_LENGTH word.
- i_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- i_Data  in  DATA_LENGTH  store data, right-aligned.
- o_Data  out  DATA_LENGTH  load result, right-aligned and extended.
- o_valid  out  1  o_Data holds a completed load this cycle.
- o_misaligned  out  1  accompanying access was misaligned or illegal.

## Operation
- OFF = log2(DATA_LENGTH/8). The word index is i_Addr[OFF +: log2(MEM_DEPTH)]. Higher address bits are ignored, so addresses wrap modulo the memory size.
- An access is misaligned when any of these hold:
  - half with i_Addr[0]=1;
  - size 10 with i_Addr[1:0]≠0;
  - size 11 with i_Addr[OFF-1:0]≠0.
- Size 11 at DATA_LENGTH=32 is identical to size 10.
- Store (i_We=1):
  - When aligned, write only the addressed byte lanes at the rising edge. The lane is the address offset. Source bits come from i_Data[7:0], [15:0] or [31:0].
  - Other lanes are untouched.
  - When misaligned, the array is not modified, and o_misaligned pulses high for exactly one cycle after that edge, with o_valid=0.
- Load (i_Re=1, i_We=0):
  - Select the lane by offset.
  - If i_unsigned=0, replicate the lane MSB to DATA_LENGTH. Otherwise fill with zeros.
  - A misaligned load returns o_Data=0 and o_valid=1 with o_misaligned=1 on the same result cycle.
- i_We=1 and i_Re=1 together: the store is performed and the load is dropped (no o_valid).
- Neither asserted: no pipeline entry. o_valid=0, and o_Data holds its last value.
- Memory contents are not initialised or cleared by reset.

## Timing
- Reset (i_rst=0, asynchronous): o_Data=0, o_valid=0, o_misaligned=0, and all read-pipeline valid bits are cleared immediately. In-flight loads are discarded. A store on the edge where reset is asserted is not performed.
- Load sampled at edge E0:
  - READ_LATENCY=1: result and o_valid are visible in the cycle after E0.
  - READ_LATENCY=2: the array is read at E0, and extension plus output registering happen at E1, so the result is visible after E1.
- Throughput is one access per cycle. Back-to-back loads produce back-to-back o_valid pulses in request order.
- Read-after-write:
  - A store at E0 followed by a load of the same word at E1 returns the new data.
  - A load and store to the same address on the same edge cannot occur (store wins, load dropped).
- A store with READ_LATENCY=2 does not disturb a load already in stage 2.
- The o_misaligned pulse for a store appears one cycle after the store edge, independent of READ_LATENCY.

## Test plan
- Reset: hold i_rst=0 mid-load (READ_LATENCY=2) → o_valid, o_Data and o_misaligned all 0 immediately. After release, no stale o_valid appears.
- Byte lanes: store word 0x11223344 @0x10, then byte 0xAB @0x12 → load word @0x10 = 0x11AB3344. Signed byte load @0x12 = 0xFFFFFFAB; unsigned = 0x000000AB.
- Half extension: store half 0x8001 @0x20 → signed half load = 0xFFFF8001, unsigned = 0x00008001. Upper half @0x22 is unchanged.
- Misalignment: store word 0xDEADBEEF @0x31 → memory unchanged and o_misaligned pulses 1 cycle. Half load @0x33 → o_valid=1, o_misaligned=1, o_Data=0.
- Pipelining and RAW: with READ_LATENCY=2, store @0x40 then loads @0x40, @0x44, @0x40 on consecutive edges → three consecutive o_valid pulses with correct data in order, the first returning the new store data.
- Wrap and conflict: load @(MEM_DEPTH*4+0x8) returns the same data as @0x8. i_We=i_Re=1 → store performed, no o_valid.

Source files
------------

// File: rtl/data_memory_bytelane.sv
// Byte-addressed data memory for the MEM stage.
// Byte/half/word/double stores with lane enables, sign/zero-extended loads,
// a 1- or 2-stage read pipeline, and misaligned-access flagging.
module data_memory_bytelane #(
  parameter int MEM_DEPTH    = 1024,
  parameter int DATA_LENGTH  = 32,
  parameter int ADDR_LENGTH  = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [ADDR_LENGTH-1:0] i_Addr,
  input  logic                   i_We,
  input  logic                   i_Re,
  input  logic [1:0]             i_size,
  input  logic                   i_unsigned,
  input  logic [DATA_LENGTH-1:0] i_Data,
  output logic [DATA_LENGTH-1:0] o_Data,
  output logic                   o_valid,
  output logic                   o_misaligned
);

  localparam int NBYTES = DATA_LENGTH / 8;
  localparam int OFF    = $clog2(NBYTES);
  localparam int IDXW   = $clog2(MEM_DEPTH);

  logic [DATA_LENGTH-1:0] mem_q [MEM_DEPTH];

  logic [OFF-1:0]         off;
  logic [IDXW-1:0]        idx;
  logic                   mis;
  logic [NBYTES-1:0]      be;
  logic [DATA_LENGTH-1:0] wdata;
  logic                   wr_fire;
  logic                   ld_fire;
  logic                   st_mis;

  // Read-path stage feeding the extension logic (direct or registered)
  logic                   p_valid;
  logic [DATA_LENGTH-1:0] p_word;
  logic [OFF-1:0]         p_off;
  logic [1:0]             p_size;
  logic                   p_uns;
  logic                   p_mis;

  logic [DATA_LENGTH-1:0] sh_word;
  logic [DATA_LENGTH-1:0] ext_d;

  logic [DATA_LENGTH-1:0] data_q;
  logic                   valid_q;
  logic                   mis_q;

  assign off = i_Addr[OFF-1:0];
  assign idx = i_Addr[OFF +: IDXW];

  // Address bits above the array index are ignored so accesses wrap.
  if (ADDR_LENGTH > OFF + IDXW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_Addr[ADDR_LENGTH-1:OFF+IDXW];
  end

  // Alignment check; size 11 covers the full word, which at 32 bits equals size 10
  always_comb begin
    mis = 1'b0;
    case (i_size)
      2'b01:   mis = i_Addr[0];
      2'b10:   mis = (i_Addr[1:0] != 2'b00);
      2'b11:   mis = (off != '0);
      default: mis = 1'b0;
    endcase
  end

  // Byte-lane enables for an aligned store; misaligned stores never fire
  always_comb begin
    be = '0;
    for (int i = 0; i < NBYTES; i++) begin
      case (i_size)
        2'b00:   be[i] = (i == int'(off));
        2'b01:   be[i] = ((i >> 1) == (int'(off) >> 1));
        2'b10:   be[i] = ((i >> 2) == (int'(off) >> 2));
        default: be[i] = 1'b1;
      endcase
    end
  end

  assign wdata   = i_Data << {off, 3'b000};
  assign wr_fire = i_We & ~mis & i_rst;
  assign ld_fire = i_Re & ~i_We;
  assign st_mis  = i_We & mis;

  // Array write; contents are deliberately not cleared by reset
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                   s2_valid_q;
    logic [DATA_LENGTH-1:0] s2_word_q;
    logic [OFF-1:0]         s2_off_q;
    logic [1:0]             s2_size_q;
    logic                   s2_uns_q;
    logic                   s2_mis_q;

    // Capture the raw array word so a later store cannot disturb this load
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        s2_valid_q <= 1'b0;
        s2_word_q  <= '0;
        s2_off_q   <= '0;
        s2_size_q  <= 2'b00;
        s2_uns_q   <= 1'b0;
        s2_mis_q   <= 1'b0;
      end else begin
        s2_valid_q <= ld_fire;
        s2_word_q  <= mem_q[idx];
        s2_off_q   <= off;
        s2_size_q  <= i_size;
        s2_uns_q   <= i_unsigned;
        s2_mis_q   <= mis;
      end
    end

    assign p_valid = s2_valid_q;
    assign p_word  = s2_word_q;
    assign p_off   = s2_off_q;
    assign p_size  = s2_size_q;
    assign p_uns   = s2_uns_q;
    assign p_mis   = s2_mis_q;
  end else begin : g_lat1
    assign p_valid = ld_fire;
    assign p_word  = mem_q[idx];
    assign p_off   = off;
    assign p_size  = i_size;
    assign p_uns   = i_unsigned;
    assign p_mis   = mis;
  end

  assign sh_word = p_word >> {p_off, 3'b000};

  // Lane extraction with sign or zero extension; misaligned loads return zero
  always_comb begin
    ext_d = sh_word;
    case (p_size)
      2'b00: begin
        ext_d      = {DATA_LENGTH{~p_uns & sh_word[7]}};
        ext_d[7:0] = sh_word[7:0];
      end
      2'b01: begin
        ext_d       = {DATA_LENGTH{~p_uns & sh_word[15]}};
        ext_d[15:0] = sh_word[15:0];
      end
      2'b10: begin
        ext_d       = {DATA_LENGTH{~p_uns & sh_word[31]}};
        ext_d[31:0] = sh_word[31:0];
      end
      default: ext_d = sh_word;
    endcase
    if (p_mis) ext_d = '0;
  end

  // Output register; store misalignment is flagged one cycle after the store edge
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      valid_q <= p_valid;
      mis_q   <= st_mis | (p_valid & p_mis);
      if (p_valid) data_q <= ext_d;
    end
  end

  assign o_Data       = data_q;
  assign o_valid      = valid_q;
  assign o_misaligned = mis_q;

endmodule
